// File: rtl/timer_pkg.sv
// Shared types for the timer subsystem.
// Holds the countdown FSM states and default width.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      EXPIRED
   } cd_state_t;

   localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing one tick every PRESCALE
// enabled cycles; clr restarts the phase at zero.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW =
      (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST =
      CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // phase counter: wraps on tick, holds when disabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Down counter with start/stop/pause, expiry pulse
// and optional auto-reload for periodic events.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done
);

   cd_state_t        state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             run_q;
   logic             tick, en, clr;

   // load and stop freeze the prescaler in the
   // cycle they are taken, so no tick slips in
   assign en = (state_q == RUN) && !load && !stop;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (clr),
      .tick (tick)
   );

   // next state: load > stop > start > tick
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      clr      = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
         clr      = 1'b1;
      end else if (stop) begin
         if (state_q == RUN) begin
            state_d = PAUSED;
         end
      end else if (start && state_q != RUN) begin
         unique case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  state_d = RUN;
                  clr     = 1'b1;
               end
            end
            PAUSED: begin
               state_d = RUN;
            end
            EXPIRED: begin
               count_d = reload_q;
               clr     = 1'b1;
               if (reload_q != '0) begin
                  state_d = RUN;
               end
            end
            default: begin
            end
         endcase
      end else if (tick) begin
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            done_d = 1'b1;
            if (auto_reload && reload_q != '0) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = EXPIRED;
            end
         end
      end
   end

   // state, count, reload and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         run_q    <= (state_d == RUN);
      end
   end

   assign count   = count_q;
   assign running = run_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances
// (PRESCALE 1 and 4) against a reference model.
module tb_countdown_timer;

   localparam int W  = 16;
   localparam int MI = 0;
   localparam int MR = 1;
   localparam int MP = 2;
   localparam int ME = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         start;
   logic         stop;
   logic         auto_reload;
   logic [W-1:0] count_a, count_b;
   logic         running_a, running_b;
   logic         done_a, done_b;

   int vectors     = 0;
   int miscompares = 0;

   int m_cnt [2];
   int m_rel [2];
   int m_ph  [2];
   int m_mode[2];
   int m_done[2];

   always #5 clk = ~clk;

   countdown_timer #(
      .WIDTH    (W),
      .PRESCALE (1)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .count       (count_a),
      .running     (running_a),
      .done        (done_a)
   );

   countdown_timer #(
      .WIDTH    (W),
      .PRESCALE (4)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .count       (count_b),
      .running     (running_b),
      .done        (done_b)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]  = 0;
         m_rel[i]  = 0;
         m_ph[i]   = 0;
         m_mode[i] = MI;
         m_done[i] = 0;
      end
   endtask

   // one clock edge of the behavioural timer
   task automatic model_step(input int i);
      int p;
      p = (i == 0) ? 1 : 4;
      m_done[i] = 0;
      if (load) begin
         m_cnt[i]  = int'(load_val);
         m_rel[i]  = int'(load_val);
         m_ph[i]   = 0;
         m_mode[i] = MI;
      end else if (stop) begin
         if (m_mode[i] == MR) m_mode[i] = MP;
      end else if (start && m_mode[i] != MR) begin
         if (m_mode[i] == MI) begin
            if (m_cnt[i] != 0) begin
               m_mode[i] = MR;
               m_ph[i]   = 0;
            end
         end else if (m_mode[i] == MP) begin
            m_mode[i] = MR;
         end else begin
            m_cnt[i] = m_rel[i];
            m_ph[i]  = 0;
            if (m_rel[i] != 0) m_mode[i] = MR;
         end
      end else if (m_mode[i] == MR) begin
         m_ph[i]++;
         if (m_ph[i] == p) begin
            m_ph[i] = 0;
            if (m_cnt[i] > 1) begin
               m_cnt[i]--;
            end else begin
               m_done[i] = 1;
               if (auto_reload && m_rel[i] != 0) begin
                  m_cnt[i] = m_rel[i];
               end else begin
                  m_cnt[i]  = 0;
                  m_mode[i] = ME;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " a.count"}, 32'(count_a), m_cnt[0]);
      check({tag, " a.run"}, 32'(running_a),
            32'(m_mode[0] == MR));
      check({tag, " a.done"}, 32'(done_a), m_done[0]);
      check({tag, " b.count"}, 32'(count_b), m_cnt[1]);
      check({tag, " b.run"}, 32'(running_b),
            32'(m_mode[1] == MR));
      check({tag, " b.done"}, 32'(done_b), m_done[1]);
   endtask

   task automatic step(
      input string  tag,
      input bit     ld,
      input int     lv,
      input bit     st,
      input bit     sp,
      input bit     ar
   );
      load        = ld;
      load_val    = W'(lv);
      start       = st;
      stop        = sp;
      auto_reload = ar;
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(
      input string tag,
      input int    n,
      input bit    ar
   );
      for (int k = 0; k < n; k++) begin
         step(tag, 0, 0, 0, 0, ar);
      end
   endtask

   initial begin
      bit ar;
      rst         = 1'b0;
      load        = 1'b0;
      load_val    = '0;
      start       = 1'b0;
      stop        = 1'b0;
      auto_reload = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      // start with zero count is ignored
      step("start0", 0, 0, 1, 0, 0);
      check("start0 run", 32'(running_a), 0);

      // basic countdown from 5
      step("t1 load", 1, 5, 0, 0, 0);
      check("t1 load cnt", 32'(count_a), 5);
      step("t1 start", 0, 0, 1, 0, 0);
      check("t1 start cnt", 32'(count_a), 5);
      idle("t1 run", 4, 0);
      check("t1 cnt1", 32'(count_a), 1);
      idle("t1 exp", 1, 0);
      check("t1 done", 32'(done_a), 1);
      check("t1 zero", 32'(count_a), 0);
      check("t1 stopped", 32'(running_a), 0);
      idle("t1 after", 2, 0);

      // restart from expired reloads preset
      step("t5 start", 0, 0, 1, 0, 0);
      check("t5 reload", 32'(count_a), 5);
      check("t5 run", 32'(running_a), 1);
      idle("t5 run", 7, 0);

      // pause and resume, PRESCALE 4
      step("t2 load", 1, 10, 0, 0, 0);
      step("t2 start", 0, 0, 1, 0, 0);
      idle("t2 run", 9, 0);
      step("t2 stop", 0, 0, 0, 1, 0);
      check("t2 paused", 32'(count_b), 8);
      idle("t2 hold", 20, 0);
      check("t2 frozen", 32'(count_b), 8);
      step("t2 resume", 0, 0, 1, 0, 0);
      idle("t2 wait", 2, 0);
      check("t2 before", 32'(count_b), 8);
      idle("t2 dec", 1, 0);
      check("t2 after", 32'(count_b), 7);
      idle("t2 tail", 30, 0);

      // periodic mode with reload 3
      step("t3 load", 1, 3, 0, 0, 1);
      step("t3 start", 0, 0, 1, 0, 1);
      idle("t3 per", 9, 1);
      check("t3 running", 32'(running_a), 1);
      idle("t3 last", 4, 0);
      check("t3 expired", 32'(running_a), 0);

      // start and stop together from RUN
      step("t4 load", 1, 20, 0, 0, 0);
      step("t4 start", 0, 0, 1, 0, 0);
      idle("t4 run", 2, 0);
      step("t4 both", 0, 0, 1, 1, 0);
      check("t4 paused", 32'(running_a), 0);

      // load during RUN
      step("t4 load9", 1, 9, 0, 0, 0);
      step("t4 go", 0, 0, 1, 0, 0);
      idle("t4 run", 2, 0);
      check("t4 seven", 32'(count_a), 7);
      step("t4 reload", 1, 2, 0, 0, 0);
      check("t4 ld cnt", 32'(count_a), 2);
      check("t4 ld idle", 32'(running_a), 0);

      // asynchronous reset mid-count
      step("t6 load", 1, 6, 0, 0, 0);
      step("t6 start", 0, 0, 1, 0, 0);
      idle("t6 run", 3, 0);
      check("t6 three", 32'(count_a), 3);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("t6 async cnt", 32'(count_a), 0);
      check("t6 async run", 32'(running_a), 0);
      check("t6 async done", 32'(done_a), 0);
      check_all("t6 reset");
      @(negedge clk);
      rst = 1'b1;
      idle("t6 idle", 3, 0);
      check("t6 stays", 32'(running_a), 0);

      // random traffic
      ar = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 15) == 0) ar = ~ar;
         step("rand",
              $urandom_range(0, 19) == 0,
              int'($urandom_range(0, 7)),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0,
              ar);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
